// File: rtl/master_mode_controller.sv
// master_mode_controller
//   Generates the timer trigger output (TRGO) from one of eight master-mode
//   sources and, optionally, counts how many triggers were emitted.
//
//   Modes (mms_i):
//     000 reset   : pulse on rising edge of ug_i
//     001 enable  : level cen_i
//     010 update  : pulse on rising edge of uev_i
//     011 compare : pulse on rising edge of cc1if_i
//     1xx OCxREF  : level oc_ref_i[mms_i[1:0]]
//
//   Parameters:
//     PULSE_W  TRGO pulse width in cycles for pulse modes (1..16)
//     CNT_W    width of the emitted-trigger counter
//
//   Ports:
//     clk_i      clock, rising edge
//     aresetn_i  synchronous active-low reset
//     mms_i      master mode select
//     msm_i      master/slave sync, 1 adds one cycle of TRGO delay
//     ug_i       software update-generation strobe
//     cen_i      counter-enable level
//     uev_i      update-event strobe
//     cc1if_i    capture/compare 1 flag strobe
//     oc_ref_i   OC1REF..OC4REF levels
//     trgo_o     trigger output
//     trg_cnt_o  count of emitted triggers (constant 0 unless
//                MMC_TRG_COUNT_EN is defined)
//
//   Build option: define MMC_TRG_COUNT_EN to include the trigger counter.
module master_mode_controller #(
  parameter int PULSE_W = 1,
  parameter int CNT_W   = 8
) (
  input  logic             clk_i,
  input  logic             aresetn_i,
  input  logic [2:0]       mms_i,
  input  logic             msm_i,
  input  logic             ug_i,
  input  logic             cen_i,
  input  logic             uev_i,
  input  logic             cc1if_i,
  input  logic [3:0]       oc_ref_i,
  output logic             trgo_o,
  output logic [CNT_W-1:0] trg_cnt_o
);

  typedef enum logic {IDLE = 1'b0, PULSE = 1'b1} state_t;

  // Four bits cover the widest legal pulse (16 cycles -> reload value 15).
  localparam logic [3:0] RELOAD = 4'(PULSE_W - 1);

  state_t     state_q, state_d;
  logic [3:0] wcnt_q, wcnt_d;

  logic [2:0] mms_q, mms_d;
  logic       msm_q, msm_d;
  logic       src_prev_q, src_prev_d;
  logic       lvl_q, lvl_d;
  logic       delay_q, delay_d;

  logic       mode_change;
  logic       level_mode_i;
  logic       level_mode_q;
  logic       pulse_src;
  logic       level_src;
  logic       event_hit;
  logic       stage1;

  // Source decode for the incoming mode.
  always_comb begin
    pulse_src = 1'b0;
    level_src = 1'b0;
    case (mms_i)
      3'b000:  pulse_src = ug_i;
      3'b001:  level_src = cen_i;
      3'b010:  pulse_src = uev_i;
      3'b011:  pulse_src = cc1if_i;
      default: level_src = oc_ref_i[mms_i[1:0]];
    endcase
  end

  assign mode_change  = (mms_i != mms_q);
  assign level_mode_i = mms_i[2] | (mms_i == 3'b001);
  assign level_mode_q = mms_q[2] | (mms_q == 3'b001);

  // An edge seen in the same cycle as a mode switch is discarded; the
  // history is cleared so a source held high is seen as a fresh edge later.
  assign event_hit = !level_mode_i && !mode_change && pulse_src && !src_prev_q;

  // FSM: state register
  always_ff @(posedge clk_i) begin
    if (!aresetn_i) begin
      state_q <= IDLE;
      wcnt_q  <= '0;
    end else begin
      state_q <= state_d;
      wcnt_q  <= wcnt_d;
    end
  end

  // FSM: next state. A new event wins over an expiring pulse.
  always_comb begin
    state_d = state_q;
    wcnt_d  = wcnt_q;
    if (mode_change || level_mode_i) begin
      state_d = IDLE;
      wcnt_d  = '0;
    end else if (event_hit) begin
      state_d = PULSE;
      wcnt_d  = RELOAD;
    end else if (state_q == PULSE) begin
      if (wcnt_q == 4'd0) begin
        state_d = IDLE;
      end else begin
        wcnt_d = wcnt_q - 4'd1;
      end
    end
  end

  // FSM: outputs. The mode mux uses the registered mode so the output only
  // ever shows one mode per cycle; the delay stage runs continuously and
  // the registered msm picks between the two taps.
  always_comb begin
    stage1 = level_mode_q ? lvl_q : (state_q == PULSE);
    trgo_o = msm_q ? delay_q : stage1;
  end

  // Datapath next values
  always_comb begin
    mms_d      = mms_i;
    msm_d      = msm_i;
    lvl_d      = level_src;
    src_prev_d = mode_change ? 1'b0 : pulse_src;
    delay_d    = mode_change ? 1'b0 : stage1;
  end

  always_ff @(posedge clk_i) begin
    if (!aresetn_i) begin
      mms_q      <= '0;
      msm_q      <= 1'b0;
      lvl_q      <= 1'b0;
      src_prev_q <= 1'b0;
      delay_q    <= 1'b0;
    end else begin
      mms_q      <= mms_d;
      msm_q      <= msm_d;
      lvl_q      <= lvl_d;
      src_prev_q <= src_prev_d;
      delay_q    <= delay_d;
    end
  end

`ifdef MMC_TRG_COUNT_EN
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             trgo_prev_q, trgo_prev_d;
  logic             level_rise;

  // Level-mode triggers are counted on TRGO rising; the history is cleared
  // on a mode switch so a level already high in the new mode still counts.
  assign level_rise = level_mode_q && trgo_o && !trgo_prev_q;

  always_comb begin
    trgo_prev_d = mode_change ? 1'b0 : trgo_o;
    cnt_d       = cnt_q;
    if (event_hit || level_rise) begin
      cnt_d = cnt_q + CNT_W'(1);
    end
  end

  always_ff @(posedge clk_i) begin
    if (!aresetn_i) begin
      cnt_q       <= '0;
      trgo_prev_q <= 1'b0;
    end else begin
      cnt_q       <= cnt_d;
      trgo_prev_q <= trgo_prev_d;
    end
  end

  assign trg_cnt_o = cnt_q;
`else
  assign trg_cnt_o = '0;
`endif

endmodule

// File: tb/tb_master_mode_controller.sv
module tb_master_mode_controller;

  localparam int CNT_W = 8;
  localparam int W_A   = 4;
  localparam int W_B   = 1;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic             aresetn;
  logic [2:0]       mms;
  logic             msm, ug, cen, uev, cc1if;
  logic [3:0]       oc_ref;
  logic             trgo_a, trgo_b;
  logic [CNT_W-1:0] cnt_a, cnt_b;

  master_mode_controller #(.PULSE_W(W_A), .CNT_W(CNT_W)) u_dut_a (
    .clk_i(clk), .aresetn_i(aresetn), .mms_i(mms), .msm_i(msm), .ug_i(ug),
    .cen_i(cen), .uev_i(uev), .cc1if_i(cc1if), .oc_ref_i(oc_ref),
    .trgo_o(trgo_a), .trg_cnt_o(cnt_a));

  master_mode_controller #(.PULSE_W(W_B), .CNT_W(CNT_W)) u_dut_b (
    .clk_i(clk), .aresetn_i(aresetn), .mms_i(mms), .msm_i(msm), .ug_i(ug),
    .cen_i(cen), .uev_i(uev), .cc1if_i(cc1if), .oc_ref_i(oc_ref),
    .trgo_o(trgo_b), .trg_cnt_o(cnt_b));

  // Next-cycle stimulus, copied onto the DUT inputs by tick().
  logic       nx_rst, nx_msm, nx_ug, nx_cen, nx_uev, nx_cc1;
  logic [2:0] nx_mms;
  logic [3:0] nx_oc;

  int errors = 0;
  int checks = 0;

  // Reference model. Pulses are tracked as cycle intervals: the last
  // accepted event cycle and the last cycle where a mode switch killed it.
  int   cyc;
  int   last_ev;
  int   kill;
  logic [2:0] m_mms_q;
  logic m_msm_q, m_src_prev, m_lvl_q, m_dly_a, m_dly_b, m_trgo_prev;
  int   m_cnt;

  function automatic logic is_lvl(logic [2:0] m);
    return m[2] || (m == 3'b001);
  endfunction

  function automatic logic pulse_hi(int w);
    if (cyc < last_ev + 1 || cyc > last_ev + w) return 1'b0;
    if (kill >= last_ev && cyc > kill) return 1'b0;
    return 1'b1;
  endfunction

  function automatic logic exp_s1(int w);
    return is_lvl(m_mms_q) ? m_lvl_q : pulse_hi(w);
  endfunction

  function automatic logic exp_trgo(int w, logic dly);
    return m_msm_q ? dly : exp_s1(w);
  endfunction

  function automatic logic [CNT_W-1:0] exp_cnt();
`ifdef MMC_TRG_COUNT_EN
    return CNT_W'(m_cnt);
`else
    return '0;
`endif
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    checks++;
    assert (obs === expv) else begin
      errors++;
      $error("FAIL %s cycle=%0d observed=%0h expected=%0h", tag, cyc, obs, expv);
    end
  endtask

  task automatic model_reset();
    last_ev = -1000; kill = -1000;
    m_mms_q = 3'b000; m_msm_q = 1'b0; m_src_prev = 1'b0; m_lvl_q = 1'b0;
    m_dly_a = 1'b0; m_dly_b = 1'b0; m_trgo_prev = 1'b0; m_cnt = 0;
  endtask

  task automatic tick();
    logic ta, chg, psrc, lsrc, ev, rise, s1a, s1b;
    @(negedge clk);
    chk("trgo_a", 32'(trgo_a), 32'(exp_trgo(W_A, m_dly_a)));
    chk("trgo_b", 32'(trgo_b), 32'(exp_trgo(W_B, m_dly_b)));
    chk("cnt_a", 32'(cnt_a), 32'(exp_cnt()));
    chk("cnt_b", 32'(cnt_b), 32'(exp_cnt()));
    aresetn = nx_rst; mms = nx_mms; msm = nx_msm; ug = nx_ug;
    cen = nx_cen; uev = nx_uev; cc1if = nx_cc1; oc_ref = nx_oc;
    if (!nx_rst) begin
      model_reset();
    end else begin
      ta  = exp_trgo(W_A, m_dly_a);
      s1a = exp_s1(W_A);
      s1b = exp_s1(W_B);
      chg = (nx_mms != m_mms_q);
      case (nx_mms)
        3'b000:  psrc = nx_ug;
        3'b010:  psrc = nx_uev;
        3'b011:  psrc = nx_cc1;
        default: psrc = 1'b0;
      endcase
      if (nx_mms == 3'b001) lsrc = nx_cen;
      else if (nx_mms[2]) lsrc = nx_oc[nx_mms[1:0]];
      else lsrc = 1'b0;
      ev   = !is_lvl(nx_mms) && !chg && psrc && !m_src_prev;
      rise = is_lvl(m_mms_q) && ta && !m_trgo_prev;
      if (ev || rise) m_cnt = (m_cnt + 1) % (1 << CNT_W);
      if (chg) kill = cyc;
      if (ev) last_ev = cyc;
      m_dly_a     = chg ? 1'b0 : s1a;
      m_dly_b     = chg ? 1'b0 : s1b;
      m_trgo_prev = chg ? 1'b0 : ta;
      m_src_prev  = chg ? 1'b0 : psrc;
      m_lvl_q     = lsrc;
      m_mms_q     = nx_mms;
      m_msm_q     = nx_msm;
    end
    cyc++;
  endtask

  task automatic ticks(input int n);
    for (int i = 0; i < n; i++) tick();
  endtask

  task automatic quiet();
    nx_ug = 1'b0; nx_uev = 1'b0; nx_cc1 = 1'b0; nx_cen = 1'b0; nx_oc = 4'h0;
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog cycle=%0d", cyc);
    $fatal(1, "watchdog expired");
  end

  initial begin
    cyc = 0;
    model_reset();
    aresetn = 1'b0; mms = 3'b000; msm = 1'b0; ug = 1'b0; cen = 1'b0;
    uev = 1'b0; cc1if = 1'b0; oc_ref = 4'h0;
    nx_rst = 1'b0; nx_mms = 3'b000; nx_msm = 1'b0; quiet();
    repeat (2) @(posedge clk);

    $display("phase reset");
    ticks(3);
    nx_rst = 1'b1;
    ticks(3);

    $display("phase update pulse, msm=0");
    nx_mms = 3'b010; ticks(3);
    nx_uev = 1'b1; tick(); nx_uev = 1'b0; ticks(7);

    $display("phase reset-mode retrigger");
    nx_mms = 3'b000; ticks(3);
    nx_ug = 1'b1; tick(); nx_ug = 1'b0; tick();
    nx_ug = 1'b1; tick(); nx_ug = 1'b0; ticks(8);

    $display("phase retrigger on expiry cycle");
    nx_ug = 1'b1; tick(); nx_ug = 1'b0; ticks(3);
    nx_ug = 1'b1; tick(); nx_ug = 1'b0; ticks(6);

    $display("phase held source counts once");
    nx_mms = 3'b010; nx_uev = 1'b1; ticks(8); nx_uev = 1'b0; ticks(6);

    $display("phase OC2REF level, msm=1");
    nx_msm = 1'b1; nx_mms = 3'b101; ticks(4);
    nx_oc = 4'b0010; ticks(10); nx_oc = 4'h0; ticks(5);

    $display("phase compare pulse cut by mode switch");
    nx_msm = 1'b0; nx_mms = 3'b011; ticks(3);
    nx_cc1 = 1'b1; tick(); nx_cc1 = 1'b0; tick();
    nx_mms = 3'b001; nx_cen = 1'b0; ticks(6);
    nx_cen = 1'b1; ticks(4); nx_cen = 1'b0; ticks(3);

    $display("phase enable level, msm=1 then msm change");
    nx_msm = 1'b1; nx_cen = 1'b1; ticks(5); nx_cen = 1'b0; ticks(3);
    nx_msm = 1'b0; ticks(3);

    $display("phase reset mid-pulse");
    nx_mms = 3'b010; ticks(3);
    nx_uev = 1'b1; tick(); nx_uev = 1'b0; ticks(2);
    nx_rst = 1'b0; tick(); nx_rst = 1'b1;
    chk("rst_trgo_a", 32'(trgo_a), 32'(1'b1));
    tick();
    chk("rst_trgo_low", 32'(trgo_a), 32'(1'b0));
    chk("rst_cnt_zero", 32'(cnt_a), 32'(0));
    ticks(3);

    $display("phase 256 update edges wrap");
    nx_rst = 1'b0; tick(); nx_rst = 1'b1; ticks(2);
    for (int i = 0; i < 255; i++) begin
      nx_uev = 1'b1; tick(); nx_uev = 1'b0; tick();
    end
`ifdef MMC_TRG_COUNT_EN
    chk("cnt_255", 32'(cnt_a), 32'(255));
`else
    chk("cnt_255", 32'(cnt_a), 32'(0));
`endif
    nx_uev = 1'b1; tick(); nx_uev = 1'b0; tick(); tick();
    chk("cnt_wrap", 32'(cnt_a), 32'(0));

    $display("phase random");
    for (int i = 0; i < 3000; i++) begin
      if ($urandom_range(0, 15) == 0) nx_mms = 3'($urandom_range(0, 7));
      if ($urandom_range(0, 31) == 0) nx_msm = ~nx_msm;
      nx_rst = ($urandom_range(0, 299) != 0);
      nx_ug  = ($urandom_range(0, 2) == 0);
      nx_uev = ($urandom_range(0, 3) == 0);
      nx_cc1 = ($urandom_range(0, 4) == 0);
      if ($urandom_range(0, 5) == 0) nx_cen = ~nx_cen;
      for (int b = 0; b < 4; b++) begin
        if ($urandom_range(0, 5) == 0) nx_oc[b] = ~nx_oc[b];
      end
      tick();
    end
    nx_rst = 1'b1; quiet(); ticks(4);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
